// File: rtl/irq_ctrl_if.sv
// AXI-Lite register-access interface used by irq_ctrl.
interface axi_lite_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic [AW-1:0] awaddr;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata;
    logic [DW/8-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/irq_ctrl.sv
// irq_ctrl: per-source gateways, claim/complete, single registered irq to the core.
// Optional build macro IRQ_CTRL_PRIO_EN adds per-source PRIO and a THRESHOLD register.
module irq_gate (
    input  logic clk,
    input  logic rst,
    input  logic src,
    input  logic edge_mode,
    input  logic claim,
    input  logic complete,
    output logic pending,
    output logic in_service
);
    logic s1, s2, s2_q, hit;

    assign hit = edge_mode ? (s2 & ~s2_q) : s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            s2_q       <= 1'b0;
            pending    <= 1'b0;
            in_service <= 1'b0;
        end else begin
            s1   <= src;
            s2   <= s1;
            s2_q <= s2;
            if (claim) begin
                pending    <= 1'b0;
                in_service <= 1'b1;
            end else begin
                if (complete)
                    in_service <= 1'b0;
                // an event coinciding with its own completion is dropped
                if (hit && !in_service && !complete)
                    pending <= 1'b1;
            end
        end
    end
endmodule

module irq_ctrl #(
    parameter int NSRC = 8,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic            clk,
    input  logic            rst,
    axi_lite_if.slave       s_axi,
    input  logic [NSRC-1:0] irq_src,
    output logic            irq_out
);
`ifdef IRQ_CTRL_PRIO_EN
    localparam int IW = 6;
`else
    localparam int IW = 4;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_DATA, R_RESP} r_state_t;

    w_state_t        w_state;
    r_state_t        r_state;
    logic [IW-1:0]   w_idx, r_idx;
    logic            awready, wready, bvalid, arready, rvalid;
    logic [DW-1:0]   rdata, rd_mux;
    logic [NSRC-1:0] enable, edge_mode, pending, in_service, elig;
    logic [NSRC-1:0] claim_vec, complete_vec;
    logic [4:0]      win_id;
    logic            wr_fire, claim_fire;
`ifdef IRQ_CTRL_PRIO_EN
    logic [NSRC-1:0][2:0] prio;
    logic [2:0]           threshold, best;
`endif

    logic unused;
    assign unused = ^{s_axi.wstrb, s_axi.wdata, s_axi.awaddr, s_axi.araddr};

    assign s_axi.awready = awready;
    assign s_axi.wready  = wready;
    assign s_axi.bvalid  = bvalid;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = arready;
    assign s_axi.rvalid  = rvalid;
    assign s_axi.rdata   = rdata;
    assign s_axi.rresp   = 2'b00;

    assign wr_fire    = (w_state == W_DATA) && s_axi.wvalid;
    assign claim_fire = (r_state == R_DATA) && (r_idx == IW'(3));

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        assign claim_vec[i]    = claim_fire && (win_id == 5'(i + 1));
        assign complete_vec[i] = wr_fire && (w_idx == IW'(4)) && (s_axi.wdata[4:0] == 5'(i + 1));
`ifdef IRQ_CTRL_PRIO_EN
        assign elig[i] = pending[i] & enable[i] & (prio[i] > threshold);
`else
        assign elig[i] = pending[i] & enable[i];
`endif
        irq_gate u_gate (
            .clk        (clk),
            .rst        (rst),
            .src        (irq_src[i]),
            .edge_mode  (edge_mode[i]),
            .claim      (claim_vec[i]),
            .complete   (complete_vec[i]),
            .pending    (pending[i]),
            .in_service (in_service[i])
        );
    end

    always_comb begin
        win_id = '0;
`ifdef IRQ_CTRL_PRIO_EN
        best = '0;
        // strict '>' keeps the lowest index on equal priority
        for (int i = 0; i < NSRC; i++)
            if (elig[i] && (win_id == '0 || prio[i] > best)) begin
                win_id = 5'(i + 1);
                best   = prio[i];
            end
`else
        for (int i = NSRC - 1; i >= 0; i--)
            if (elig[i]) win_id = 5'(i + 1);
`endif
    end

    always_comb begin
        rd_mux = '0;
        case (r_idx)
            IW'(0): rd_mux = DW'(pending);
            IW'(1): rd_mux = DW'(enable);
            IW'(2): rd_mux = DW'(edge_mode);
            IW'(3): rd_mux = DW'(win_id);
            IW'(5): rd_mux = DW'(in_service);
            default: ;
        endcase
`ifdef IRQ_CTRL_PRIO_EN
        if (r_idx == IW'(6)) rd_mux = DW'(threshold);
        for (int i = 0; i < NSRC; i++)
            if (r_idx == IW'(8 + i)) rd_mux = DW'(prio[i]);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enable    <= '0;
            edge_mode <= '0;
`ifdef IRQ_CTRL_PRIO_EN
            prio      <= {NSRC{3'd1}};
            threshold <= '0;
`endif
        end else if (wr_fire) begin
            if (w_idx == IW'(1)) enable    <= s_axi.wdata[NSRC-1:0];
            if (w_idx == IW'(2)) edge_mode <= s_axi.wdata[NSRC-1:0];
`ifdef IRQ_CTRL_PRIO_EN
            if (w_idx == IW'(6)) threshold <= s_axi.wdata[2:0];
            for (int i = 0; i < NSRC; i++)
                if (w_idx == IW'(8 + i)) prio[i] <= s_axi.wdata[2:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) irq_out <= 1'b0;
        else     irq_out <= |elig;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state <= W_IDLE;
            awready <= 1'b0;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            w_idx   <= '0;
        end else begin
            case (w_state)
                W_IDLE:
                    if (awready && s_axi.awvalid) begin
                        w_idx   <= s_axi.awaddr[IW+1:2];
                        awready <= 1'b0;
                        wready  <= 1'b1;
                        w_state <= W_DATA;
                    end else begin
                        awready <= 1'b1;
                    end
                W_DATA:
                    if (s_axi.wvalid) begin
                        wready  <= 1'b0;
                        bvalid  <= 1'b1;
                        w_state <= W_RESP;
                    end
                W_RESP:
                    if (s_axi.bready) begin
                        bvalid  <= 1'b0;
                        awready <= 1'b1;
                        w_state <= W_IDLE;
                    end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= R_IDLE;
            arready <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                R_IDLE:
                    if (arready && s_axi.arvalid) begin
                        r_idx   <= s_axi.araddr[IW+1:2];
                        arready <= 1'b0;
                        r_state <= R_DATA;
                    end else begin
                        arready <= 1'b1;
                    end
                R_DATA: begin
                    rdata   <= rd_mux;
                    rvalid  <= 1'b1;
                    r_state <= R_RESP;
                end
                R_RESP:
                    if (s_axi.rready) begin
                        rvalid  <= 1'b0;
                        arready <= 1'b1;
                        r_state <= R_IDLE;
                    end
                default: r_state <= R_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_irq_ctrl.sv
// Directed, table-driven bench for irq_ctrl plus hand sequences for timing corners.
module tb_irq_ctrl;
    localparam int NSRC = 8;
`ifdef IRQ_CTRL_PRIO_EN
    localparam logic [31:0] EXP_3C = 32'd1, EXP_18 = 32'd7;
`else
    localparam logic [31:0] EXP_3C = 32'd0, EXP_18 = 32'd0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NSRC-1:0] irq_src = '0;
    logic            irq_out;
    int              n_vec = 0, n_bad = 0;

    axi_lite_if #(.AW(32), .DW(32)) bus ();

    irq_ctrl #(.NSRC(NSRC), .AW(32), .DW(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_axi   (bus),
        .irq_src (irq_src),
        .irq_out (irq_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit              wr;
        logic [31:0]     addr;
        logic [31:0]     data;
        logic [NSRC-1:0] src;
        int              settle;
        logic [31:0]     exp;
        logic            exp_irq;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                input logic [NSRC-1:0] src, input int settle,
                                input logic [31:0] exp, input logic exp_irq);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.src = src;
        v.settle = settle; v.exp = exp; v.exp_irq = exp_irq;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_bad++;
        $display("FAIL %s: handshake timeout", name);
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input string name);
        int n;
        bus.awaddr = a; bus.awvalid = 1'b1; n = 0;
        while (!bus.awready && n < 20) begin tick(1); n++; end
        if (n >= 20) timeout({name, " aw"});
        tick(1);
        bus.awvalid = 1'b0; bus.wdata = d; bus.wvalid = 1'b1; n = 0;
        while (!bus.wready && n < 20) begin tick(1); n++; end
        if (n >= 20) timeout({name, " w"});
        tick(1);
        bus.wvalid = 1'b0; bus.bready = 1'b1; n = 0;
        while (!bus.bvalid && n < 20) begin tick(1); n++; end
        if (n >= 20) timeout({name, " b"});
        check({name, " bresp"}, 32'(bus.bresp), 32'd0);
        tick(1);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, input logic [31:0] exp, input int stall,
                            input string name);
        int n;
        bus.araddr = a; bus.arvalid = 1'b1; n = 0;
        while (!bus.arready && n < 20) begin tick(1); n++; end
        if (n >= 20) timeout({name, " ar"});
        tick(1);
        bus.arvalid = 1'b0; n = 0;
        while (!bus.rvalid && n < 20) begin tick(1); n++; end
        if (n >= 20) timeout({name, " r"});
        check({name, " rdata"}, bus.rdata, exp);
        check({name, " rresp"}, 32'(bus.rresp), 32'd0);
        for (int s = 0; s < stall; s++) begin
            tick(1);
            check($sformatf("%s hold%0d rvalid", name, s), 32'(bus.rvalid), 32'd1);
            check($sformatf("%s hold%0d rdata", name, s), bus.rdata, exp);
        end
        bus.rready = 1'b1;
        tick(1);
        bus.rready = 1'b0;
    endtask

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = 4'hF;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        tick(3);
        check("rst irq_out", 32'(irq_out), 32'd0);
        check("rst awready", 32'(bus.awready), 32'd0);
        check("rst arready", 32'(bus.arready), 32'd0);
        check("rst bvalid", 32'(bus.bvalid), 32'd0);
        check("rst rvalid", 32'(bus.rvalid), 32'd0);
        check("rst rdata", bus.rdata, 32'd0);
        rst = 1'b0;
        tick(1);

        // level source 0: exact latency, claim, re-pend after complete
        axi_write(32'h04, 32'h01, "lvl enable");
        irq_src = 8'h01;
        tick(3);
        check("lat3 irq_out", 32'(irq_out), 32'd0);
        tick(1);
        check("lat4 irq_out", 32'(irq_out), 32'd1);
        axi_read(32'h0C, 32'd1, 0, "lvl claim");
        check("post-claim irq_out", 32'(irq_out), 32'd0);
        axi_read(32'h14, 32'h01, 0, "lvl inservice");
        axi_write(32'h10, 32'd1, "lvl complete");
        tick(3);
        check("re-pend irq_out", 32'(irq_out), 32'd1);
        axi_read(32'h0C, 32'd1, 0, "lvl claim2");
        irq_src = '0;
        tick(3);
        axi_write(32'h10, 32'd1, "lvl complete2");

        // edge source 2: one 3-clk pulse gives a single event
        axi_write(32'h08, 32'h04, "edge cfg");
        axi_write(32'h04, 32'h04, "edge enable");
        irq_src = 8'h04;
        tick(3);
        irq_src = '0;
        tick(4);

        add(0, 32'h00, 0, 8'h00, 0, 32'h04, 1);
        add(0, 32'h0C, 0, 8'h00, 0, 32'd3,  1);
        add(0, 32'h0C, 0, 8'h00, 2, 32'd0,  0);
        add(0, 32'h00, 0, 8'h04, 5, 32'h00, 0);
        add(0, 32'h14, 0, 8'h00, 3, 32'h04, 0);
        add(1, 32'h10, 3, 8'h00, 0, 32'h00, 0);
        add(0, 32'h00, 0, 8'h00, 3, 32'h00, 0);
        add(1, 32'h08, 0, 8'h00, 0, 32'h00, 0);
        add(1, 32'h04, 32'hFF, 8'h00, 0, 32'h00, 0);
        add(0, 32'h00, 0, 8'h22, 5, 32'h22, 1);
        add(0, 32'h0C, 0, 8'h00, 3, 32'd2,  1);
        add(0, 32'h0C, 0, 8'h00, 0, 32'd6,  1);
        add(0, 32'h0C, 0, 8'h00, 2, 32'd0,  0);
        add(0, 32'h14, 0, 8'h00, 0, 32'h22, 0);
        add(1, 32'h10, 0, 8'h00, 0, 32'h00, 0);
        add(1, 32'h10, 9, 8'h00, 0, 32'h00, 0);
        add(0, 32'h14, 0, 8'h00, 0, 32'h22, 0);
        add(0, 32'h00, 0, 8'h00, 0, 32'h00, 0);
        add(1, 32'h10, 2, 8'h00, 0, 32'h00, 0);
        add(1, 32'h10, 6, 8'h00, 0, 32'h00, 0);
        add(0, 32'h14, 0, 8'h00, 0, 32'h00, 0);
        add(0, 32'h3C, 0, 8'h00, 0, EXP_3C, 0);
        add(1, 32'h18, 7, 8'h00, 0, 32'h00, 0);
        add(0, 32'h18, 0, 8'h00, 0, EXP_18, 0);
        add(1, 32'h18, 0, 8'h00, 0, 32'h00, 0);
        add(1, 32'h04, 0, 8'h00, 0, 32'h00, 0);
        add(0, 32'h00, 0, 8'h08, 5, 32'h08, 0);
        add(0, 32'h0C, 0, 8'h08, 0, 32'd0,  0);

        foreach (tbl[k]) begin
            irq_src = tbl[k].src;
            tick(tbl[k].settle);
            check($sformatf("v%0d irq_out", k), 32'(irq_out), 32'(tbl[k].exp_irq));
            if (tbl[k].wr) axi_write(tbl[k].addr, tbl[k].data, $sformatf("v%0d", k));
            else           axi_read(tbl[k].addr, tbl[k].exp, 0, $sformatf("v%0d", k));
        end

        // enabling an already-pending source raises irq_out right after the write
        axi_write(32'h04, 32'h08, "late enable");
        check("late enable irq_out", 32'(irq_out), 32'd1);
        axi_read(32'h0C, 32'd4, 0, "late claim");
        irq_src = '0;
        tick(3);
        axi_write(32'h10, 32'd4, "late complete");
        axi_read(32'h04, 32'h08, 5, "stall");

`ifdef IRQ_CTRL_PRIO_EN
        axi_write(32'h2C, 32'd5, "prio3");
        axi_write(32'h24, 32'd5, "prio1");
        axi_write(32'h38, 32'd2, "prio6");
        axi_write(32'h18, 32'd2, "thresh");
        axi_write(32'h04, 32'hFF, "prio enable");
        irq_src = 8'hFF;
        tick(5);
        irq_src = '0;
        tick(3);
        axi_read(32'h0C, 32'd2, 0, "prio claim a");
        axi_read(32'h0C, 32'd4, 0, "prio claim b");
        axi_read(32'h0C, 32'd0, 0, "prio claim c");
`endif

        // reset in the middle of a write clears state and applies nothing
        axi_write(32'h04, 32'h01, "mid enable");
        irq_src = 8'h01;
        tick(5);
        irq_src = '0;
        bus.awaddr = 32'h08; bus.awvalid = 1'b1;
        tick(2);
        bus.awvalid = 1'b0;
        rst = 1'b1;
        tick(1);
        check("mid rst irq_out", 32'(irq_out), 32'd0);
        check("mid rst awready", 32'(bus.awready), 32'd0);
        check("mid rst wready", 32'(bus.wready), 32'd0);
        rst = 1'b0;
        tick(3);
        axi_read(32'h00, 32'h00, 0, "mid pending");
        axi_read(32'h04, 32'h00, 0, "mid enable rd");
        axi_read(32'h08, 32'h00, 0, "mid edge rd");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
